// File: rtl/spi_byte_sequencer.sv
// Feeds single-byte SPI driver transactions from a TX FIFO and returns each received byte
// through a first-word-fall-through RX FIFO, with inter-byte gap and per-phase timeout.
module spi_byte_sequencer #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [7:0]                 drv_data_in,
    output logic                       drv_start,
    input  logic                       drv_en,
    input  logic [7:0]                 drv_data_out,
    input  logic                       err_clr,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [$clog2(DEPTH):0]     tx_level,
    output logic [$clog2(DEPTH):0]     rx_level,
    output logic [2:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // ready/valid outputs depend only on registered levels, never on the partner's signal.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_EN   = 3'd2,
        WAIT_DONE = 3'd3,
        CAPTURE   = 3'd4,
        GAP       = 3'd5,
        ERR       = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      drv_data_q, drv_data_d;
    logic            err_q, err_d;
    logic            load;

    // ---------------- TX FIFO ----------------
    logic [7:0]      tx_mem_q [DEPTH];
    logic [AW-1:0]   tx_wr_q, tx_rd_q;
    logic [LW-1:0]   tx_level_q;
    logic            tx_push, tx_pop;

    assign tx_ready = (tx_level_q != LW'(DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = load;
    assign tx_level = tx_level_q;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_level_q <= tx_level_q + 1'b1;
                2'b01:   tx_level_q <= tx_level_q - 1'b1;
                default: tx_level_q <= tx_level_q;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]      rx_mem_q [DEPTH];
    logic [AW-1:0]   rx_wr_q, rx_rd_q;
    logic [LW-1:0]   rx_level_q;
    logic            rx_push, rx_pop;

    assign rx_valid = (rx_level_q != '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = (state_q == CAPTURE);
    assign rx_level = rx_level_q;
    // Empty FIFO presents zero so the head never shows stale or unwritten storage.
    assign rx_data  = rx_valid ? rx_mem_q[rx_rd_q] : 8'h00;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_q] <= drv_data_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_level_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_level_q <= rx_level_q + 1'b1;
                2'b01:   rx_level_q <= rx_level_q - 1'b1;
                default: rx_level_q <= rx_level_q;
            endcase
        end
    end

    // ---------------- Sequencer FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            gap_q      <= '0;
            drv_data_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            drv_data_q <= drv_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                // Only launch when the eventual capture is guaranteed an RX slot.
                if ((tx_level_q != '0) && (rx_level_q < LW'(DEPTH))) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = WAIT_EN;
            WAIT_EN: begin
                if (drv_en) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            WAIT_DONE: begin
                if (!drv_en) begin
                    state_d = CAPTURE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            CAPTURE: state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP: begin
                if (int'(gap_q) >= GAP_CYCLES - 1) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer and gap counter restart on every state change.
    always_comb begin
        timer_d    = timer_q;
        gap_d      = gap_q;
        drv_data_d = drv_data_q;
        err_d      = err_q;
        if (state_d != state_q) begin
            timer_d = '0;
            gap_d   = '0;
        end else begin
            if ((state_q == WAIT_EN) || (state_q == WAIT_DONE)) timer_d = timer_q + 1'b1;
            if (state_q == GAP) gap_d = gap_q + 1'b1;
        end
        if (load) drv_data_d = tx_mem_q[tx_rd_q];
        if ((state_d == ERR) && (state_q != ERR)) begin
            err_d = 1'b1;
        end else if ((state_q == ERR) && err_clr) begin
            err_d = 1'b0;
        end
    end

    assign drv_start   = (state_q == START);
    assign drv_data_in = drv_data_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer: a driver model echoes each byte XOR 0x99,
// a scoreboard tracks launched bytes and returned bytes in order.
module tb_spi_byte_sequencer;

    localparam int DEPTH   = 4;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int EN_LEN  = 3;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd6;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    drv_data_in;
    logic          drv_start;
    logic          drv_en;
    logic [7:0]    drv_data_out;
    logic          err_clr;
    logic          busy;
    logic          timeout_err;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic [2:0]    dbg_state;

    spi_byte_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .drv_data_in(drv_data_in), .drv_start(drv_start), .drv_en(drv_en),
        .drv_data_out(drv_data_out), .err_clr(err_clr),
        .busy(busy), .timeout_err(timeout_err),
        .tx_level(tx_level), .rx_level(rx_level), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int start_cnt = 0;
    bit drv_respond = 1'b1;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    // Start monitor: every pulse must present the next byte the host pushed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && drv_start === 1'b1) begin
                start_cnt++;
                if (tx_q.size() == 0) fail_now("start_unexpected");
                else check("start_data", {24'h0, drv_data_in}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    // Driver model: enable for EN_LEN cycles after a start, then return byte ^ 0x99.
    initial begin
        logic [7:0] cap;
        drv_en       = 1'b0;
        drv_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (drv_start === 1'b1 && drv_respond) begin
                cap    = drv_data_in;
                drv_en = 1'b1;
                repeat (EN_LEN) @(negedge clk);
                drv_data_out = cap ^ 8'h99;
                drv_en       = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input vec_t v, input bit expect_rx);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("push_wait_ready");
        end else begin
            tx_data  = v.tx;
            tx_valid = 1'b1;
            tx_q.push_back(v.tx);
            if (expect_rx) exp_q.push_back(v.rx);
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic pop_one(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rx_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now({name, "_wait_valid"});
        end else begin
            if (exp_q.size() == 0) fail_now({name, "_extra_rx"});
            else check(name, {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (dbg_state === s) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        @(negedge clk);
        wait_state(S_IDLE, name);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_drv_start"},   {31'h0, drv_start},   32'h0);
        check({tag, "_drv_data_in"}, {24'h0, drv_data_in}, 32'h0);
        check({tag, "_rx_data"},     {24'h0, rx_data},     32'h0);
        check({tag, "_rx_valid"},    {31'h0, rx_valid},    32'h0);
        check({tag, "_tx_ready"},    {31'h0, tx_ready},    32'h1);
        check({tag, "_busy"},        {31'h0, busy},        32'h0);
        check({tag, "_timeout_err"}, {31'h0, timeout_err}, 32'h0);
        check({tag, "_tx_level"},    32'(tx_level),        32'h0);
        check({tag, "_rx_level"},    32'(rx_level),        32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int s0;
        int k;
        bit seen;

        tbl[0]  = '{8'hA5, 8'h3C};  tbl[1]  = '{8'h5A, 8'hC3};
        tbl[2]  = '{8'h01, 8'h98};  tbl[3]  = '{8'h02, 8'h9B};
        tbl[4]  = '{8'h03, 8'h9A};  tbl[5]  = '{8'h04, 8'h9D};
        tbl[6]  = '{8'h00, 8'h99};  tbl[7]  = '{8'hFF, 8'h66};
        tbl[8]  = '{8'h3C, 8'hA5};  tbl[9]  = '{8'h7E, 8'hE7};
        tbl[10] = '{8'h80, 8'h19};  tbl[11] = '{8'h11, 8'h88};
        tbl[12] = '{8'hC0, 8'h59};  tbl[13] = '{8'h0F, 8'h96};

        rst = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single byte
        s0 = start_cnt;
        push_byte(tbl[0], 1'b1);
        pop_one("single_rx");
        wait_idle("single_idle");
        check("single_busy", {31'h0, busy}, 32'h0);
        check("single_starts", 32'(start_cnt - s0), 32'd1);
        check("single_hold_drv_data", {24'h0, drv_data_in}, 32'hA5);

        // Burst: fill the TX FIFO while one transaction is in flight
        s0 = start_cnt;
        push_byte(tbl[1], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) fail_now("burst_busy");
        for (int i = 2; i <= 5; i++) push_byte(tbl[i], 1'b1);
        check("burst_tx_ready", {31'h0, tx_ready}, 32'h0);
        check("burst_tx_level", 32'(tx_level), 32'd4);
        for (int i = 0; i < 5; i++) pop_one("burst_rx");
        wait_idle("burst_idle");
        check("burst_starts", 32'(start_cnt - s0), 32'd5);

        // Back-pressure: RX never drained, so only DEPTH transactions may run
        s0 = start_cnt;
        for (int i = 6; i <= 11; i++) push_byte(tbl[i], 1'b1);
        repeat (150) @(negedge clk);
        check("bp_rx_level", 32'(rx_level), 32'd4);
        check("bp_tx_level", 32'(tx_level), 32'd2);
        check("bp_busy", {31'h0, busy}, 32'h0);
        check("bp_starts", 32'(start_cnt - s0), 32'd4);
        check("bp_rx_head", {24'h0, rx_data}, {24'h0, exp_q[0]});
        for (int i = 0; i < 6; i++) pop_one("bp_rx");
        wait_idle("bp_idle");
        check("bp_starts_all", 32'(start_cnt - s0), 32'd6);

        // Timeout: driver ignores the start
        drv_respond = 1'b0;
        push_byte(tbl[12], 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (drv_start === 1'b1) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("to_start");
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin k = i; break; end
        end
        check("to_err_latency", 32'(k), 32'd65);
        check("to_state_err", {29'h0, dbg_state}, {29'h0, S_ERR});
        check("to_rx_level", 32'(rx_level), 32'd0);
        check("to_busy", {31'h0, busy}, 32'h1);
        push_byte(tbl[13], 1'b1);
        check("to_tx_accept", 32'(tx_level), 32'd1);
        check("to_err_sticky", {31'h0, timeout_err}, 32'h1);
        drv_respond = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_err_cleared", {31'h0, timeout_err}, 32'h0);
        pop_one("to_next_rx");
        wait_idle("to_idle");

        // Simultaneous RX pop and CAPTURE push at rx_level 1
        push_byte(tbl[2], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rx_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) fail_now("sim_first_valid");
        push_byte(tbl[3], 1'b1);
        wait_state(S_CAPTURE, "sim_capture");
        check("sim_level_before", 32'(rx_level), 32'd1);
        check("sim_head_first", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("sim_level_after", 32'(rx_level), 32'd1);
        pop_one("sim_second_rx");
        wait_idle("sim_idle");

        // Reset during WAIT_DONE
        push_byte(tbl[7], 1'b1);
        wait_state(S_WAIT_DONE, "rst_wait_done");
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        tx_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        s0 = start_cnt;
        repeat (40) @(negedge clk);
        check("midrst_no_start", 32'(start_cnt - s0), 32'd0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_rx_level", 32'(rx_level), 32'd0);

        check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_tx_q_empty", 32'(tx_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
